// File: rtl/adxl345_spi_responder_if.sv
// SPI bus between the accelerometer controller (master) and the emulated
// ADXL345 target (slave). All four wires are single-bit, mode 3.
`timescale 1ns/1ps
interface adxl345_spi_responder_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_cs,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs,
        output spi_miso
    );
endinterface

// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-interface emulator: SPI mode-3 target serving DEVID,
// three host-writable config registers and a coherent X/Y/Z snapshot.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | chip select high, waiting for a synchronised cs fall
// CMD   | shifting in the command byte {RW, MB, A[5:0]}
// RD    | shifting register data out on MISO, one byte per 8 SCLK cycles
// WR    | shifting data bytes in and committing them to the config regs
`timescale 1ns/1ps
module adxl345_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    adxl345_spi_responder_if.slave spi,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic        sample_valid,
    output logic        data_ready,
    output logic [7:0]  bw_rate,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic        cfg_wr
);

    typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic sclk_s, mosi_s, cs_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  tx_byte;
    logic [5:0]  addr;
    logic        mb;
    logic        miso_q;
    logic        rd_seen_x0;

    logic [15:0] shadow_x, shadow_y, shadow_z;
    logic [15:0] pend_x, pend_y, pend_z;
    logic        pend_valid;

    logic [7:0]  cmd_byte;
    logic [5:0]  next_addr;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        at_idle;

    // Resynchronise the SPI pins; cs resets to "asserted" so that a cs line
    // held low across reset release never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '1;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign cmd_byte  = {shift_in[6:0], mosi_s};
    assign next_addr = mb ? addr + 6'd1 : addr;
    assign at_idle   = (state == IDLE) || cs_rise;
    assign spi.spi_miso = miso_q;

    // Register read mux: the command byte's address while decoding, otherwise
    // the address of the byte that follows the one just completed.
    always_comb begin
        rd_addr = (state == CMD) ? cmd_byte[5:0] : next_addr;
        rd_data = 8'h00;
        case (rd_addr)
            6'h00:   rd_data = DEVID;
            6'h2C:   rd_data = bw_rate;
            6'h2D:   rd_data = power_ctl;
            6'h31:   rd_data = data_format;
            6'h32:   rd_data = shadow_x[7:0];
            6'h33:   rd_data = shadow_x[15:8];
            6'h34:   rd_data = shadow_y[7:0];
            6'h35:   rd_data = shadow_y[15:8];
            6'h36:   rd_data = shadow_z[7:0];
            6'h37:   rd_data = shadow_z[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // Frame FSM, config register writes and sample snapshot handling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_in    <= 8'h00;
            tx_byte     <= 8'h00;
            addr        <= 6'h00;
            mb          <= 1'b0;
            miso_q      <= 1'b1;
            rd_seen_x0  <= 1'b0;
            bw_rate     <= 8'h0A;
            power_ctl   <= 8'h00;
            data_format <= 8'h00;
            cfg_wr      <= 1'b0;
            data_ready  <= 1'b0;
            shadow_x    <= 16'h0000;
            shadow_y    <= 16'h0000;
            shadow_z    <= 16'h0000;
            pend_x      <= 16'h0000;
            pend_y      <= 16'h0000;
            pend_z      <= 16'h0000;
            pend_valid  <= 1'b0;
        end else begin
            cfg_wr <= 1'b0;
            if (sclk_rise) begin
                shift_in <= cmd_byte;
            end

            if (cs_rise) begin
                state   <= IDLE;
                miso_q  <= 1'b1;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state      <= CMD;
                            bit_cnt    <= 3'd0;
                            rd_seen_x0 <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                addr <= cmd_byte[5:0];
                                mb   <= cmd_byte[6];
                                if (cmd_byte[7]) begin
                                    state   <= RD;
                                    tx_byte <= rd_data;
                                end else begin
                                    state <= WR;
                                end
                            end
                        end
                    end
                    RD: begin
                        if (sclk_fall) begin
                            miso_q  <= tx_byte[7];
                            tx_byte <= {tx_byte[6:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr == 6'h32) begin
                                    rd_seen_x0 <= 1'b1;
                                end
                                if (addr == 6'h37 && rd_seen_x0) begin
                                    data_ready <= 1'b0;
                                end
                                addr    <= next_addr;
                                tx_byte <= rd_data;
                            end
                        end
                    end
                    WR: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (addr)
                                    6'h2C: begin
                                        bw_rate <= cmd_byte;
                                        cfg_wr  <= 1'b1;
                                    end
                                    6'h2D: begin
                                        power_ctl <= cmd_byte;
                                        cfg_wr    <= 1'b1;
                                    end
                                    6'h31: begin
                                        data_format <= cmd_byte;
                                        cfg_wr      <= 1'b1;
                                    end
                                    default: ;
                                endcase
                                addr <= next_addr;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Snapshot last so a new sample overrides a same-cycle data_ready clear.
            if (sample_valid && at_idle) begin
                shadow_x   <= x_in;
                shadow_y   <= y_in;
                shadow_z   <= z_in;
                pend_valid <= 1'b0;
                data_ready <= 1'b1;
            end else if (sample_valid) begin
                pend_x     <= x_in;
                pend_y     <= y_in;
                pend_z     <= z_in;
                pend_valid <= 1'b1;
            end else if (pend_valid && at_idle) begin
                shadow_x   <= pend_x;
                shadow_y   <= pend_y;
                shadow_z   <= pend_z;
                pend_valid <= 1'b0;
                data_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Bench for the ADXL345 SPI responder: directed frames plus randomized
// frames checked against a register-level model of the accelerometer.
`timescale 1ns/1ps
module tb_adxl345_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] x_in, y_in, z_in;
    logic        sample_valid;
    logic        data_ready;
    logic [7:0]  bw_rate, power_ctl, data_format;
    logic        cfg_wr;

    adxl345_spi_responder_if spi_if ();

    adxl345_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi          (spi_if),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .sample_valid (sample_valid),
        .data_ready   (data_ready),
        .bw_rate      (bw_rate),
        .power_ctl    (power_ctl),
        .data_format  (data_format),
        .cfg_wr       (cfg_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cfg_cnt  = 0;

    // Count config-write pulses as they happen.
    always @(posedge clk) begin
        if (cfg_wr === 1'b1) cfg_cnt++;
    end

    // Reference model: the accelerometer as the host sees it.
    logic [7:0]  m_bw, m_pc, m_df;
    logic [15:0] m_x, m_y, m_z;
    logic [15:0] m_px, m_py, m_pz;
    logic        m_pend;
    logic        m_dr;

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            6'h00:   return 8'hE5;
            6'h2C:   return m_bw;
            6'h2D:   return m_pc;
            6'h31:   return m_df;
            6'h32:   return m_x[7:0];
            6'h33:   return m_x[15:8];
            6'h34:   return m_y[7:0];
            6'h35:   return m_y[15:8];
            6'h36:   return m_z[7:0];
            6'h37:   return m_z[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_bw = 8'h0A; m_pc = 8'h00; m_df = 8'h00;
        m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
        m_pend = 1'b0; m_dr = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_bw_rate"}, {24'h0, bw_rate}, {24'h0, m_bw});
        check({tag, "_power_ctl"}, {24'h0, power_ctl}, {24'h0, m_pc});
        check({tag, "_data_format"}, {24'h0, data_format}, {24'h0, m_df});
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input bit in_frame);
        @(negedge clk);
        x_in = x; y_in = y; z_in = z; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (in_frame) begin
            m_px = x; m_py = y; m_pz = z; m_pend = 1'b1;
        end else begin
            m_x = x; m_y = y; m_z = z; m_dr = 1'b1;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_if.spi_cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        spi_if.spi_cs   = 1'b1;
        spi_if.spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
        if (m_pend) begin
            m_x = m_px; m_y = m_py; m_z = m_pz; m_pend = 1'b0; m_dr = 1'b1;
        end
    endtask

    // Initiator drives MOSI at SCLK fall, samples MISO just before SCLK rise.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_if.spi_sclk = 1'b0;
            spi_if.spi_mosi = tx[7-i];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], spi_if.spi_miso};
            spi_if.spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    // Read frame of n bytes; a new sample is strobed after byte sa (0 = never).
    task automatic read_frame(input string tag, input logic [5:0] a, input bit mb, input int n,
                              input int sa, input logic [15:0] sx, input logic [15:0] sy,
                              input logic [15:0] sz);
        logic [7:0] rx, exp;
        logic [5:0] cur;
        bit seen;
        cs_begin();
        xfer_bits({1'b1, mb, a}, 8, rx);
        cur = a;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp = m_read(cur);
            xfer_bits(8'h00, 8, rx);
            check($sformatf("%s_b%0d", tag, k), {24'h0, rx}, {24'h0, exp});
            if (cur == 6'h32) seen = 1'b1;
            if (cur == 6'h37 && seen) m_dr = 1'b0;
            check($sformatf("%s_dr%0d", tag, k), {31'h0, data_ready}, {31'h0, m_dr});
            if (k + 1 == sa) strobe(sx, sy, sz, 1'b1);
            cur = mb ? cur + 6'd1 : cur;
        end
        cs_end();
        check({tag, "_dr_end"}, {31'h0, data_ready}, {31'h0, m_dr});
        check({tag, "_miso_idle"}, {31'h0, spi_if.spi_miso}, 32'h1);
    endtask

    task automatic write_frame(input string tag, input logic [5:0] a, input bit mb, input int n,
                               input logic [7:0] d0);
        logic [7:0] rx, d;
        logic [5:0] cur;
        int c0, exp_pulses;
        c0 = cfg_cnt;
        exp_pulses = 0;
        cs_begin();
        xfer_bits({1'b0, mb, a}, 8, rx);
        cur = a;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : 8'($urandom);
            xfer_bits(d, 8, rx);
            case (cur)
                6'h2C: begin m_bw = d; exp_pulses++; end
                6'h2D: begin m_pc = d; exp_pulses++; end
                6'h31: begin m_df = d; exp_pulses++; end
                default: ;
            endcase
            cur = mb ? cur + 6'd1 : cur;
        end
        cs_end();
        check({tag, "_cfg_pulses"}, 32'(cfg_cnt - c0), 32'(exp_pulses));
        check_regs(tag);
    endtask

    logic [7:0] rx_tmp;
    logic [5:0] wlist [6];
    int c_before;

    initial begin
        wlist = '{6'h2C, 6'h2D, 6'h31, 6'h00, 6'h10, 6'h33};
        reset_n = 1'b0;
        spi_if.spi_cs = 1'b1; spi_if.spi_sclk = 1'b1; spi_if.spi_mosi = 1'b0;
        x_in = 16'h0; y_in = 16'h0; z_in = 16'h0; sample_valid = 1'b0;
        m_reset();
        repeat (5) @(negedge clk);
        check("rst_miso", {31'h0, spi_if.spi_miso}, 32'h1);
        check("rst_dr", {31'h0, data_ready}, 32'h0);
        check("rst_cfg_wr", {31'h0, cfg_wr}, 32'h0);
        check_regs("rst");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Device ID, data_ready untouched.
        read_frame("t1_devid", 6'h00, 1'b0, 1, 0, 16'h0, 16'h0, 16'h0);

        // Six-byte burst from one snapshot.
        strobe(16'h1234, 16'hFF80, 16'h0100, 1'b0);
        check("t2_dr_set", {31'h0, data_ready}, 32'h1);
        read_frame("t2_burst", 6'h32, 1'b1, 6, 0, 16'h0, 16'h0, 16'h0);

        // Config write and a write to a read-only register.
        write_frame("t3_pc", 6'h2D, 1'b0, 1, 8'h08);
        write_frame("t3_ro", 6'h00, 1'b0, 1, 8'h55);
        read_frame("t3_devid", 6'h00, 1'b0, 1, 0, 16'h0, 16'h0, 16'h0);

        // Mid-burst sample stays pending until the frame ends.
        strobe(16'h5555, 16'h6666, 16'h7777, 1'b0);
        read_frame("t4_old", 6'h32, 1'b1, 6, 2, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        read_frame("t4_new", 6'h32, 1'b1, 2, 0, 16'h0, 16'h0, 16'h0);

        // Partial write byte is dropped.
        c_before = cfg_cnt;
        cs_begin();
        xfer_bits(8'h31, 8, rx_tmp);
        xfer_bits(8'hFF, 5, rx_tmp);
        cs_end();
        check("t5_partial_cfg", 32'(cfg_cnt - c_before), 32'h0);
        check_regs("t5_partial");
        write_frame("t5_full", 6'h31, 1'b0, 1, 8'h0B);

        // Address wrap 0x3F -> 0x00.
        read_frame("t6_wrap", 6'h3F, 1'b1, 2, 0, 16'h0, 16'h0, 16'h0);

        // Randomized traffic.
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 2))
                0: strobe(16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
                1: read_frame($sformatf("rnd%0d_rd", it),
                              ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(6'h2A, 6'h3F)),
                              1'($urandom_range(0, 1)), $urandom_range(1, 7),
                              $urandom_range(0, 3),
                              16'($urandom), 16'($urandom), 16'($urandom));
                default: write_frame($sformatf("rnd%0d_wr", it), wlist[$urandom_range(0, 5)],
                                     1'($urandom_range(0, 1)), $urandom_range(1, 3),
                                     8'($urandom));
            endcase
        end

        // Reset in the middle of a write frame, cs held low across release.
        cs_begin();
        xfer_bits(8'h2D, 8, rx_tmp);
        xfer_bits(8'hF0, 3, rx_tmp);
        @(negedge clk);
        reset_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check("rstmid_miso", {31'h0, spi_if.spi_miso}, 32'h1);
        check("rstmid_dr", {31'h0, data_ready}, 32'h0);
        check_regs("rstmid");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        c_before = cfg_cnt;
        xfer_bits(8'h2D, 8, rx_tmp);
        xfer_bits(8'h77, 8, rx_tmp);
        cs_end();
        check("rstmid_nocs_cfg", 32'(cfg_cnt - c_before), 32'h0);
        check_regs("rstmid_nocs");
        write_frame("rstmid_after", 6'h2D, 1'b0, 1, 8'h08);
        read_frame("rstmid_devid", 6'h00, 1'b0, 1, 0, 16'h0, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
